aes_dec_key_sched: RTL and testbench
====================================

Name: aes_dec_key_sched

Overview:
- Sequential AES-128 round-key generator for the inverse cipher.
- Accepts a 128-bit cipher key, runs the forward expansion one round per cycle to reach round key 10, then streams round keys 10 down to 0. Each step back regenerates the previous round key using the inverse key-expansion recurrence, so no 44-word buffer is needed.
- Sits between the key-load interface and the decryption round datapath, next to the combinational forward key_expansion block. It shares the same sub_word, rot_word and S_box primitives.

Parameters:
- LENGTH, 128, key and round-key width in bits; only 128 is supported.
- Nk, LENGTH/32, key length in 32-bit words.
- Nr, 10, number of cipher rounds.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  cipher key offered.
- key_ready  output  1  block can accept a key; high only in IDLE.
- key  input  LENGTH  cipher key; w0 is key[127:96], w3 is key[31:0].
- rk_valid  output  1  round key on rk is valid.
- rk_ready  input  1  consumer accepts rk.
- rk  output  LENGTH  round key; word 0 is in the MSBs (FIPS-197 order).
- rk_round  output  4  round index of rk, 10 down to 0.
- rk_last  output  1  high with rk_valid when rk_round==0.
- busy  output  1  high in FWD or OUT.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; the round counter and the rk register are 0.
  - Outputs: key_ready=1, rk_valid=0, rk_last=0, busy=0, rk=0, rk_round=0.
- States: IDLE, FWD, OUT.
- IDLE:
  - On key_valid&&key_ready, register key into rk, set the counter to 0 and go to FWD.
- FWD:
  - Each cycle, counter r increments by 1 and rk becomes the forward next round key using Rcon[r+1].
  - Forward step from words v0..v3 to n0..n3:
    - n0 = v0 ^ SubWord(RotWord(v3)) ^ {Rcon,24'h0}
    - n1 = n0 ^ v1, n2 = n1 ^ v2, n3 = n2 ^ v3
    - RotWord is a left byte rotate: {b1,b2,b3,b0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Rcon is generated from a table indexed by the counter, not by multiplication.
  - After the 10th step (r==10), go to OUT.
- Latency: rk_valid rises exactly Nr+1=11 cycles after the key handshake edge, with rk_round=10.
- OUT:
  - rk_valid=1 and rk_round=r.
  - On rk_valid&&rk_ready with r>0, rk becomes the previous round key and r decrements.
  - Inverse step from v0..v3 (round r) to u0..u3 (round r-1):
    - u3 = v3^v2, u2 = v2^v1, u1 = v1^v0
    - u0 = v0 ^ SubWord(RotWord(u3)) ^ {Rcon[r],24'h0}
  - On the handshake with r==0 (rk_last=1), return to IDLE; rk_valid falls the next cycle.
- Backpressure: while rk_valid&&!rk_ready, rk, rk_round and rk_last hold stable.
- Throughput: one round key per cycle while rk_ready is held high. Eleven handshakes complete the sequence.
- key_valid while busy is ignored; key_ready is 0 and there is no queueing.
- A new key can be accepted in the cycle after the final handshake.
- A single sub_word instance is shared between the forward and inverse paths; its input is muxed by state.
- Reset mid-FWD or mid-OUT aborts immediately to the reset values. There is no partial output after reset release.
- rk_round never wraps below 0 or exceeds Nr.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - On the final handshake (rk_last), the rk register is cleared to 0 on the same edge as the return to IDLE.
  - In IDLE, rk reads 0.
  - Reset also zeroes rk, as it does without the macro.
- Undefined:
  - rk retains round key 0, which equals the original cipher key, after completion until the next key load.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk_valid rises 11 cycles after the handshake.
  - rk sequence starts d014f9a8c9ee2589e13f0cc8b6630ca6 (round 10), then ac7766f319fadc2128d12941575c006e (round 9).
  - Round 1 is a0fafe1788542cb123a339392a6c7605; round 0 is the key itself with rk_last=1.
- All-zero key:
  - First rk is b4ef5bcb3e92e21123e951cf6f8f188e (round 10).
  - Round 1 is 62636363626363636263636362636363; round 0 is all zero.
- Backpressure: FIPS key with rk_ready toggled in a random pattern:
  - rk and rk_round stay stable while stalled.
  - Exactly 11 handshakes complete, in order 10..0.
- key_valid held high through a whole run:
  - key_ready=0 during FWD and OUT.
  - The second key is accepted only in the cycle after the rk_last handshake; its round-10 key is correct.
- rst_n pulsed low at FWD cycle 5 and again at OUT round 6:
  - All outputs return to reset values asynchronously.
  - A subsequent load of the FIPS key produces the correct full sequence.
- With AES_KEY_ZEROIZE_EN defined: after the rk_last handshake, rk==0 the following cycle. Without the macro, rk==2b7e151628aed2a6abf7158809cf4f3c.

Source files
------------

// File: rtl/aes_dec_key_sched.sv
// rtl/aes_dec_key_sched.sv - AES-128 inverse-cipher round-key generator, keys 10..0; optional AES_KEY_ZEROIZE_EN
module aes_dec_key_sched #(
    parameter int LENGTH = 128,
    parameter int Nk     = LENGTH / 32,
    parameter int Nr     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [LENGTH-1:0] key,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [LENGTH-1:0] rk,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [LENGTH-1:0]   rk_q, rk_d;

    logic [31:0] v [4];
    logic [31:0] u0, u1, u2, u3, n0, n1, n2, n3;
    logic [31:0] sw_in, sw_out;
    logic [3:0]  rcon_idx;
    logic [7:0]  rcon;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] s_box(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {s_box(w[31:24]), s_box(w[23:16]), s_box(w[15:8]), s_box(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) v[i] = 32'h0;
        for (int i = 0; i < Nk; i++) v[i] = rk_q[LENGTH-1-32*i -: 32];

        u3 = v[3] ^ v[2];
        u2 = v[2] ^ v[1];
        u1 = v[1] ^ v[0];

        // One shared sub_word: the inverse path needs RotWord of the regenerated u3
        sw_in  = (state_q == OUT) ? rot_word(u3) : rot_word(v[3]);
        sw_out = sub_word(sw_in);

        rcon_idx = (state_q == FWD) ? cnt_q + 4'd1 : cnt_q;
        case (rcon_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase

        n0 = v[0] ^ sw_out ^ {rcon, 24'h0};
        n1 = n0 ^ v[1];
        n2 = n1 ^ v[2];
        n3 = n2 ^ v[3];
        u0 = v[0] ^ sw_out ^ {rcon, 24'h0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    rk_d    = key;
                    cnt_d   = 4'd0;
                    state_d = FWD;
                end
            end
            FWD: begin
                // Extra cycle at r==Nr gives the fixed Nr+1 load-to-valid latency
                if (cnt_q == 4'(Nr)) begin
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    rk_d  = {n0, n1, n2, n3};
                end
            end
            OUT: begin
                if (rk_ready) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
`ifdef AES_KEY_ZEROIZE_EN
                        rk_d    = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        rk_d  = {u0, u1, u2, u3};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rk_q    <= rk_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = (state_q == OUT);
    assign rk_round  = (state_q == OUT) ? cnt_q : 4'd0;
    assign rk_last   = (state_q == OUT) && (cnt_q == 4'd0);
    assign rk        = rk_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// tb/tb_aes_dec_key_sched.sv - scoreboard bench for aes_dec_key_sched
module tb_aes_dec_key_sched;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    aes_dec_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   rnd;
        logic         last;
        logic         chk;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    int           pops  = 0;
    logic [127:0] fk [11];
    logic [127:0] zk [11];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rk_valid === 1'b1) begin
            if (rk_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rk", {124'h0, rk_round}, 128'hffff);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("rk_round", {124'h0, rk_round}, {124'h0, e.rnd});
                    chk("rk_last", {127'h0, rk_last}, {127'h0, e.last});
                    if (e.chk) chk("rk_value", rk, e.rk);
                end
            end else if (sb.size() > 0) begin
                e = sb[0];
                chk("stall_round", {124'h0, rk_round}, {124'h0, e.rnd});
                if (e.chk) chk("stall_rk", rk, e.rk);
            end
        end
    end

    task automatic push_seq(input bit zero);
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rk   = zero ? zk[r] : fk[r];
            e.rnd  = 4'(r);
            e.last = (r == 0);
            e.chk  = zero ? (r == 0 || r == 1 || r == 10) : 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic load(input logic [127:0] k, input bit zero, input bit hold);
        int n;
        key = k;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_ready", {127'h0, key_ready}, 128'h1);
        push_seq(zero);
        @(posedge clk); #1;
        if (!hold) key_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rk_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 128'(n), 128'd11);
        chk("first_round", {124'h0, rk_round}, 128'd10);
    endtask

    task automatic wait_done(input logic [127:0] after_rk);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", 128'(sb.size()), 128'd0);
        chk("valid_fall", {127'h0, rk_valid}, 128'h0);
        chk("ready_idle", {127'h0, key_ready}, 128'h1);
`ifdef AES_KEY_ZEROIZE_EN
        chk("rk_after", rk, 128'h0);
`else
        chk("rk_after", rk, after_rk);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, {127'h0, key_ready}, 128'h1);
        chk({tag, "_rk_valid"}, {127'h0, rk_valid}, 128'h0);
        chk({tag, "_rk_last"}, {127'h0, rk_last}, 128'h0);
        chk({tag, "_busy"}, {127'h0, busy}, 128'h0);
        chk({tag, "_rk"}, rk, 128'h0);
        chk({tag, "_rk_round"}, {124'h0, rk_round}, 128'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        fk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) zk[i] = 128'h0;
        zk[1]  = 128'h62636363626363636263636362636363;
        zk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n = 1'b0;
        key_valid = 1'b0;
        key = 128'h0;
        rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 key, consumer always ready
        rk_ready = 1'b1;
        load(fk[0], 1'b0, 1'b0);
        wait_valid();
        wait_done(fk[0]);

        // all-zero key
        load(128'h0, 1'b1, 1'b0);
        wait_valid();
        wait_done(128'h0);

        // random backpressure
        rk_ready = 1'b0;
        p0 = pops;
        load(fk[0], 1'b0, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 600) begin
            rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("bp_handshakes", 128'(pops - p0), 128'd11);
        chk("bp_valid_fall", {127'h0, rk_valid}, 128'h0);
        rk_ready = 1'b1;
        @(posedge clk); #1;

        // key_valid held high across a whole run; second key waits for IDLE
        load(fk[0], 1'b0, 1'b1);
        key = 128'h0;
        push_seq(1'b1);
        n = 0;
        while (sb.size() > 11 && n < 300) begin
            chk("busy_key_ready", {127'h0, key_ready}, 128'h0);
            @(posedge clk); #1;
            n++;
        end
        chk("ready_after_last", {127'h0, key_ready}, 128'h1);
        @(posedge clk); #1;
        chk("second_accepted", {127'h0, busy}, 128'h1);
        key_valid = 1'b0;
        wait_valid();
        wait_done(128'h0);

        // reset during forward expansion
        load(fk[0], 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_fwd");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_fwd_no_out", {127'h0, rk_valid}, 128'h0);

        // reset during output at round 6
        load(fk[0], 1'b0, 1'b0);
        wait_valid();
        n = 0;
        while (rk_round != 4'd6 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_round6", {124'h0, rk_round}, 128'd6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_out");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_no_out", {127'h0, rk_valid}, 128'h0);

        // full run after the reset aborts
        load(fk[0], 1'b0, 1'b0);
        wait_valid();
        wait_done(fk[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
